control_unit_seq: RTL and testbench

// Sequenced decode-stage control unit. Decodes an OPC_W-bit opcode into EX/MEM/WB control bundles,

---
 rtl/cu_pkg.sv | 22 ++
 rtl/cu_decode.sv | 37 +++
 rtl/control_unit_seq.sv | 65 ++++++
 tb/tb_control_unit_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// cu_pkg: opcode map, control-field encodings and FSM states for the decode-stage control unit
package cu_pkg;
  typedef enum logic {S_DECODE, S_IMM} state_t;
  localparam logic [5:0] OP_LDD = 6'b000001;
  localparam logic [5:0] OP_STD = 6'b000010;
  localparam logic [5:0] OP_ADD = 6'b000011;
  localparam logic [5:0] OP_NOT = 6'b000100;
  localparam logic [5:0] OP_NOP = 6'b000101;
  localparam logic [5:0] OP_LDM = 6'b000110;
  localparam logic [5:0] OP_SHL = 6'b000111;
  localparam logic [5:0] OP_SHR = 6'b001000;
  localparam logic [3:0] ALU_NOT = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SHL = 4'd3;
  localparam logic [3:0] ALU_SHR = 4'd4;
  localparam logic [3:0] MEM_LOAD = 4'b1000;
  localparam logic [3:0] MEM_STORE = 4'b0110;
  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_IMM = 2'b10;
  localparam logic [2:0] BUBBLE_WB = 3'b011;
endpackage

// File: rtl/cu_decode.sv
// cu_decode: combinational opcode -> EX/MEM/WB bundle plus operand-use and two-word flags
module cu_decode
  import cu_pkg::*;
#(
  parameter int OPC_W = 6,
  parameter int ALUOP_W = 4
) (
  input  logic [OPC_W-1:0]   opcode,
  output logic [ALUOP_W+1:0] ex,
  output logic [3:0]         mem,
  output logic [2:0]         wb,
  output logic               is_real,
  output logic               uses_rs,
  output logic               uses_rt,
  output logic               is_two_word
);
  always_comb begin
    ex = '0;
    mem = '0;
    wb = BUBBLE_WB;
    is_real = 1'b0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    is_two_word = 1'b0;
    case (opcode)
      OPC_W'(OP_NOT): begin ex = {ALUOP_W'(ALU_NOT), 2'b10}; wb = {1'b1, WB_ALU}; is_real = 1'b1; uses_rs = 1'b1; end
      OPC_W'(OP_ADD): begin ex = {ALUOP_W'(ALU_ADD), 2'b10}; wb = {1'b1, WB_ALU}; is_real = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
      OPC_W'(OP_SHL): begin ex = {ALUOP_W'(ALU_SHL), 2'b11}; wb = {1'b1, WB_ALU}; is_real = 1'b1; uses_rs = 1'b1; end
      OPC_W'(OP_SHR): begin ex = {ALUOP_W'(ALU_SHR), 2'b11}; wb = {1'b1, WB_ALU}; is_real = 1'b1; uses_rs = 1'b1; end
      OPC_W'(OP_LDD): begin mem = MEM_LOAD; wb = {1'b1, WB_MEM}; is_real = 1'b1; uses_rs = 1'b1; end
      OPC_W'(OP_STD): begin mem = MEM_STORE; wb = BUBBLE_WB; is_real = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
      OPC_W'(OP_LDM): is_two_word = 1'b1;
      OPC_W'(OP_NOP): ;
      default: ;
    endcase
  end
endmodule

// File: rtl/control_unit_seq.sv
// control_unit_seq: sequenced decode control with load-use stall, LDM immediate word, flush and bubble count
module control_unit_seq
  import cu_pkg::*;
#(
  parameter int OPC_W = 6,
  parameter int ALUOP_W = 4,
  parameter int RA_W = 3,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [RA_W-1:0]    rs_addr,
  input  logic [RA_W-1:0]    rt_addr,
  input  logic [RA_W-1:0]    rd_addr,
  input  logic               ex_mem_read,
  input  logic [RA_W-1:0]    ex_rd_addr,
  input  logic               flush,
  output logic               stall,
  output logic               imm_take,
  output logic [ALUOP_W+1:0] ex_signals,
  output logic [3:0]         mem_signals,
  output logic [2:0]         wb_signals,
  output logic               ctrl_valid,
  output logic [CNT_W-1:0]   bubble_cnt
);
  state_t state;
  logic [ALUOP_W+1:0] d_ex;
  logic [3:0] d_mem;
  logic [2:0] d_wb;
  logic d_real, d_rs, d_rt, d_two;
  logic dec_ok, hazard, issue, go_imm;
  // destination of the pending LDM; held for the immediate write, not yet exported
  logic [RA_W-1:0] unused_ldm_rd;
  cu_decode #(.OPC_W(OPC_W), .ALUOP_W(ALUOP_W)) u_dec (
    .opcode(opcode), .ex(d_ex), .mem(d_mem), .wb(d_wb),
    .is_real(d_real), .uses_rs(d_rs), .uses_rt(d_rt), .is_two_word(d_two)
  );
  assign dec_ok = state == S_DECODE && !flush && instr_valid;
  assign hazard = ex_mem_read && ((d_rs && ex_rd_addr == rs_addr) || (d_rt && ex_rd_addr == rt_addr));
  assign stall = dec_ok && hazard;
  assign imm_take = state == S_IMM && !flush;
  assign issue = dec_ok && !hazard && !d_two;
  assign go_imm = dec_ok && !hazard && d_two;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_DECODE;
      ex_signals <= '0;
      mem_signals <= '0;
      wb_signals <= BUBBLE_WB;
      ctrl_valid <= 1'b0;
      bubble_cnt <= '0;
      unused_ldm_rd <= '0;
    end else begin
      state <= go_imm ? S_IMM : S_DECODE;
      ex_signals <= issue ? d_ex : '0;
      mem_signals <= issue ? d_mem : '0;
      wb_signals <= imm_take ? {1'b1, WB_IMM} : issue ? d_wb : BUBBLE_WB;
      ctrl_valid <= imm_take || (issue && d_real);
      if (stall && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + CNT_W'(1);
      if (go_imm) unused_ldm_rd <= rd_addr;
    end
  end
endmodule

// File: tb/tb_control_unit_seq.sv
// tb_control_unit_seq: directed scenarios plus randomized run against a spec-level model
module tb_control_unit_seq;
  localparam int OPC_W = 6, ALUOP_W = 4, RA_W = 3, CNT_W = 2;
  logic clk = 1'b0, rst = 1'b0;
  logic instr_valid = 1'b0, ex_mem_read = 1'b0, flush = 1'b0;
  logic [OPC_W-1:0] opcode = '0;
  logic [RA_W-1:0] rs_addr = '0, rt_addr = '0, rd_addr = '0, ex_rd_addr = '0;
  logic stall, imm_take, ctrl_valid;
  logic [ALUOP_W+1:0] ex_signals;
  logic [3:0] mem_signals;
  logic [2:0] wb_signals;
  logic [CNT_W-1:0] bubble_cnt;
  int checks = 0, failures = 0;
  logic [5:0] e_ex;
  logic [3:0] e_mem;
  logic [2:0] e_wb;
  logic e_cv, e_stall, e_imm;
  logic [1:0] e_cnt;
  bit m_imm;

  typedef struct packed {
    logic [5:0] ex; logic [3:0] mem; logic [2:0] wb;
    logic real_op; logic rs; logic rt; logic two;
  } dec_t;

  control_unit_seq #(.OPC_W(OPC_W), .ALUOP_W(ALUOP_W), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr), .flush(flush),
    .stall(stall), .imm_take(imm_take), .ex_signals(ex_signals),
    .mem_signals(mem_signals), .wb_signals(wb_signals),
    .ctrl_valid(ctrl_valid), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  function automatic dec_t spec_dec(input logic [5:0] op);
    case (op)
      6'b000100: return '{6'b000110, 4'b0000, 3'b101, 1'b1, 1'b1, 1'b0, 1'b0};
      6'b000011: return '{6'b001010, 4'b0000, 3'b101, 1'b1, 1'b1, 1'b1, 1'b0};
      6'b000111: return '{6'b001111, 4'b0000, 3'b101, 1'b1, 1'b1, 1'b0, 1'b0};
      6'b001000: return '{6'b010011, 4'b0000, 3'b101, 1'b1, 1'b1, 1'b0, 1'b0};
      6'b000001: return '{6'b000000, 4'b1000, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0};
      6'b000010: return '{6'b000000, 4'b0110, 3'b011, 1'b1, 1'b1, 1'b1, 1'b0};
      6'b000110: return '{6'b000000, 4'b0000, 3'b011, 1'b0, 1'b0, 1'b0, 1'b1};
      default:   return '{6'b000000, 4'b0000, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0};
    endcase
  endfunction

  task automatic bub();
    e_ex = '0; e_mem = '0; e_wb = 3'b011; e_cv = 1'b0;
  endtask

  task automatic do_reset();
    instr_valid = 1'b0; ex_mem_read = 1'b0; flush = 1'b0; opcode = '0;
    rst = 1'b0; #2; rst = 1'b1;
    bub(); e_cnt = '0; m_imm = 0;
  endtask

  task automatic apply(input logic vld, input logic [5:0] op, input logic [2:0] rs, input logic [2:0] rt,
                       input logic [2:0] rd, input logic emr, input logic [2:0] erd, input logic fl);
    dec_t d;
    instr_valid = vld; opcode = op; rs_addr = rs; rt_addr = rt; rd_addr = rd;
    ex_mem_read = emr; ex_rd_addr = erd; flush = fl;
    #1;
    d = spec_dec(op);
    e_stall = !fl && !m_imm && vld && emr && ((d.rs && erd == rs) || (d.rt && erd == rt));
    e_imm = m_imm && !fl;
  endtask

  task automatic tick();
    dec_t d;
    bit haz, fl, vld;
    d = spec_dec(opcode);
    fl = flush; vld = instr_valid;
    haz = ex_mem_read && ((d.rs && ex_rd_addr == rs_addr) || (d.rt && ex_rd_addr == rt_addr));
    @(posedge clk); #1;
    if (fl) begin bub(); m_imm = 0; end
    else if (m_imm) begin e_ex = '0; e_mem = '0; e_wb = 3'b110; e_cv = 1'b1; m_imm = 0; end
    else if (!vld) bub();
    else if (haz) begin bub(); e_cnt = (e_cnt == 2'b11) ? e_cnt : e_cnt + 2'b01; end
    else if (d.two) begin bub(); m_imm = 1; end
    else begin e_ex = d.ex; e_mem = d.mem; e_wb = d.wb; e_cv = d.real_op; end
  endtask

  task automatic test_alu();
    do_reset();
    apply(1, 6'b000011, 3'd1, 3'd2, 3'd3, 0, 3'd0, 0);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL alu_stall got=%b want=0", stall); end
    tick();
    checks++;
    if ({ex_signals, wb_signals, ctrl_valid} !== {6'b001010, 3'b101, 1'b1}) begin
      failures++; $display("FAIL add_issue got ex=%b wb=%b cv=%b want ex=001010 wb=101 cv=1", ex_signals, wb_signals, ctrl_valid);
    end
    apply(1, 6'b000100, 3'd4, 3'd5, 3'd6, 0, 3'd0, 0);
    tick();
    checks++;
    if ({ex_signals, mem_signals, wb_signals, ctrl_valid} !== {6'b000110, 4'b0000, 3'b101, 1'b1}) begin
      failures++; $display("FAIL not_issue got ex=%b mem=%b wb=%b cv=%b want ex=000110 wb=101 cv=1", ex_signals, mem_signals, wb_signals, ctrl_valid);
    end
  endtask

  task automatic test_hazard();
    do_reset();
    apply(1, 6'b000011, 3'd1, 3'd2, 3'd3, 1, 3'd2, 0);
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL hazard_stall got=%b want=1", stall); end
    tick();
    checks++;
    if ({ex_signals, mem_signals, wb_signals, ctrl_valid, bubble_cnt} !== {6'b0, 4'b0, 3'b011, 1'b0, 2'd1}) begin
      failures++; $display("FAIL hazard_bubble got ex=%b mem=%b wb=%b cv=%b cnt=%0d want bubble cnt=1", ex_signals, mem_signals, wb_signals, ctrl_valid, bubble_cnt);
    end
    apply(1, 6'b000011, 3'd1, 3'd2, 3'd3, 0, 3'd2, 0);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL hazard_release got=%b want=0", stall); end
    tick();
    checks++;
    if ({ex_signals, ctrl_valid, bubble_cnt} !== {6'b001010, 1'b1, 2'd1}) begin
      failures++; $display("FAIL hazard_reissue got ex=%b cv=%b cnt=%0d want ex=001010 cv=1 cnt=1", ex_signals, ctrl_valid, bubble_cnt);
    end
  endtask

  task automatic test_ldm();
    do_reset();
    apply(1, 6'b000110, 3'd2, 3'd2, 3'd5, 1, 3'd2, 0);
    checks++; if ({stall, imm_take} !== 2'b00) begin failures++; $display("FAIL ldm_first_comb got=%b want=00", {stall, imm_take}); end
    tick();
    checks++;
    if ({ex_signals, mem_signals, wb_signals, ctrl_valid} !== {6'b0, 4'b0, 3'b011, 1'b0}) begin
      failures++; $display("FAIL ldm_first_bubble got ex=%b mem=%b wb=%b cv=%b", ex_signals, mem_signals, wb_signals, ctrl_valid);
    end
    apply(1, 6'h2A, 3'd2, 3'd2, 3'd0, 1, 3'd2, 0);
    checks++; if ({stall, imm_take} !== 2'b01) begin failures++; $display("FAIL ldm_imm_comb got=%b want=01", {stall, imm_take}); end
    tick();
    checks++;
    if ({ex_signals, mem_signals, wb_signals, ctrl_valid, bubble_cnt} !== {6'b0, 4'b0, 3'b110, 1'b1, 2'd0}) begin
      failures++; $display("FAIL ldm_imm_regs got ex=%b mem=%b wb=%b cv=%b cnt=%0d want wb=110 cv=1 cnt=0", ex_signals, mem_signals, wb_signals, ctrl_valid, bubble_cnt);
    end
  endtask

  task automatic test_flush();
    do_reset();
    apply(1, 6'b000110, 3'd0, 3'd0, 3'd1, 0, 3'd0, 0);
    tick();
    apply(1, 6'h2A, 3'd0, 3'd0, 3'd0, 0, 3'd0, 1);
    checks++; if ({stall, imm_take} !== 2'b00) begin failures++; $display("FAIL flush_comb got=%b want=00", {stall, imm_take}); end
    tick();
    checks++;
    if ({wb_signals, ctrl_valid} !== {3'b011, 1'b0}) begin
      failures++; $display("FAIL flush_bubble got wb=%b cv=%b want wb=011 cv=0", wb_signals, ctrl_valid);
    end
    apply(1, 6'b000011, 3'd1, 3'd2, 3'd3, 0, 3'd0, 0);
    checks++; if (imm_take !== 1'b0) begin failures++; $display("FAIL flush_state got imm_take=%b want=0", imm_take); end
    tick();
    checks++;
    if ({ex_signals, wb_signals, ctrl_valid} !== {6'b001010, 3'b101, 1'b1}) begin
      failures++; $display("FAIL flush_then_add got ex=%b wb=%b cv=%b", ex_signals, wb_signals, ctrl_valid);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] want [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1, 6'b000001, 3'd4, 3'd0, 3'd1, 1, 3'd4, 0);
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sat_stall%0d got=%b want=1", i, stall); end
      tick();
      checks++; if (bubble_cnt !== want[i]) begin failures++; $display("FAIL sat_cnt%0d got=%0d want=%0d", i, bubble_cnt, want[i]); end
    end
    apply(1, 6'b111111, 3'd4, 3'd4, 3'd1, 1, 3'd4, 0);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL unknown_stall got=%b want=0", stall); end
    tick();
    checks++;
    if ({ex_signals, mem_signals, wb_signals, ctrl_valid, bubble_cnt} !== {6'b0, 4'b0, 3'b011, 1'b0, 2'd3}) begin
      failures++; $display("FAIL unknown_bubble got ex=%b mem=%b wb=%b cv=%b cnt=%0d", ex_signals, mem_signals, wb_signals, ctrl_valid, bubble_cnt);
    end
  endtask

  task automatic test_reset();
    do_reset();
    apply(1, 6'b000011, 3'd1, 3'd1, 3'd1, 1, 3'd1, 0);
    tick();
    apply(1, 6'b000110, 3'd0, 3'd0, 3'd7, 0, 3'd0, 0);
    tick();
    apply(1, 6'h2A, 3'd0, 3'd0, 3'd0, 0, 3'd0, 0);
    rst = 1'b0; #1;
    checks++;
    if ({ex_signals, mem_signals, wb_signals, ctrl_valid, bubble_cnt, imm_take} !== {6'b0, 4'b0, 3'b011, 1'b0, 2'd0, 1'b0}) begin
      failures++; $display("FAIL async_reset got ex=%b mem=%b wb=%b cv=%b cnt=%0d imm=%b", ex_signals, mem_signals, wb_signals, ctrl_valid, bubble_cnt, imm_take);
    end
    do_reset();
    apply(1, 6'b000011, 3'd1, 3'd2, 3'd3, 0, 3'd0, 0);
    checks++; if (imm_take !== 1'b0) begin failures++; $display("FAIL reset_mid_ldm imm_take=%b want=0", imm_take); end
    tick();
    checks++; if (ex_signals !== 6'b001010) begin failures++; $display("FAIL reset_then_add got ex=%b want=001010", ex_signals); end
  endtask

  task automatic test_random();
    logic [5:0] ops [9] = '{6'b000101, 6'b000100, 6'b000011, 6'b000111, 6'b001000, 6'b000001, 6'b000010, 6'b000110, 6'b111111};
    do_reset();
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 99) < 85, ops[$urandom_range(0, 8)], 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), $urandom_range(0, 99) < 8);
      checks++;
      if ({stall, imm_take} !== {e_stall, e_imm}) begin
        failures++; $display("FAIL rand_comb%0d got stall/imm=%b want=%b", i, {stall, imm_take}, {e_stall, e_imm});
      end
      tick();
      checks++;
      if ({ex_signals, mem_signals, wb_signals, ctrl_valid, bubble_cnt} !== {e_ex, e_mem, e_wb, e_cv, e_cnt}) begin
        failures++;
        $display("FAIL rand_regs%0d got ex=%b mem=%b wb=%b cv=%b cnt=%0d want ex=%b mem=%b wb=%b cv=%b cnt=%0d",
                 i, ex_signals, mem_signals, wb_signals, ctrl_valid, bubble_cnt, e_ex, e_mem, e_wb, e_cv, e_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_hazard();
    test_ldm();
    test_flush();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
